spk_out_tx: RTL and testbench
=============================

Name: spk_out_tx

Overview:
- Spike transmitter for one node.
- Takes per-neuron fire decisions from the soma (fire bit plus neuron index) and buffers fired neuron IDs in a small FIFO.
- For each fired neuron, it emits one spike flit per configured destination onto the node's NoC output through a valid/ready handshake.
- It sits between the soma's fire output and the router injection port.

Parameters:
- FW, 59, flit width
- FTW, 3, flit type width
- NNW, 12, neuron index width
- SW, 24, spike field width
- DST_WIDTH, 21, destination word width (x+y+r2+r1+flg)
- DST_DEPTH, 4, destination table entries
- FIFO_AW, 4, spike FIFO address width (depth 2^FIFO_AW = 16)
- SPK_TYPE, 3'b010, flit type code for spike flits

Ports:
- clk  in  1  block clock
- rst_n  in  1  reset; synchronous, active-low
- soma_fire_vld  in  1  soma result valid this cycle
- soma_spk_out_fire  in  1  fire decision, qualified by soma_fire_vld
- soma_neuron_id  in  NNW  index of the neuron being evaluated
- config_spk_enable  in  1  accept new fires when high
- config_spk_clear  in  1  flush FIFO and abort transmission
- config_dst_we  in  1  destination table write strobe
- config_dst_waddr  in  log2(DST_DEPTH)  table write address
- config_dst_wdata  in  DST_WIDTH  table write data
- config_dst_num  in  log2(DST_DEPTH)+1  number of valid destinations, 0..DST_DEPTH
- flit_out  out  FW  spike flit
- flit_out_vld  out  1  flit valid
- flit_out_rdy  in  1  downstream ready
- spk_out_busy  out  1  FIFO non-empty or flit pending
- spk_out_overflow  out  1  sticky: a fire was dropped on full FIFO
- spk_fifo_cnt  out  FIFO_AW+1  FIFO occupancy

Behaviour:
- Reset (rst_n low at clk edge):
  - flit_out=0, flit_out_vld=0, spk_out_busy=0, spk_out_overflow=0, spk_fifo_cnt=0.
  - FIFO pointers are zero; FSM goes to IDLE.
  - Destination table contents are undefined; software rewrites the table after reset.
- Push:
  - Condition: soma_fire_vld & soma_spk_out_fire & config_spk_enable & !config_spk_clear.
  - Writes soma_neuron_id into the FIFO.
  - Fullness is evaluated before any same-cycle pop. On full, the fire is dropped, spk_out_overflow is set and stays set until reset or clear, and cnt stays at 16.
- Flit format, MSB to LSB: {SPK_TYPE[FTW], dst[DST_WIDTH], spk[SW], zeros[FW-FTW-DST_WIDTH-SW]}.
  - spk = zero-extended neuron ID.
  - With defaults, the field order is type 3 bits, dst 21, spk 24, pad 11.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD:
    - Pop the FIFO head into nid_r and set dst_idx=0.
    - If config_dst_num==0, the ID is discarded: go to LOAD if the FIFO is still non-empty, else IDLE.
    - Otherwise register flit_out={SPK_TYPE, table[0], nid_r, 0}, assert flit_out_vld, and go to SEND.
  - SEND:
    - While flit_out_vld & !flit_out_rdy, flit_out and flit_out_vld hold stable.
    - On handshake with dst_idx < config_dst_num-1: dst_idx++ and the next flit is loaded in the same cycle (back-to-back, one flit per cycle).
    - On handshake at the last destination: flit_out_vld drops, then go to LOAD if the FIFO is non-empty, else IDLE.
- Latency: a fire in cycle t with the FIFO empty and IDLE gives FIFO write at t+1, LOAD at t+2, and flit_out_vld high at t+3.
- Table writes:
  - Take effect on the next clk and are allowed at any time.
  - A flit already registered is unaffected; later destinations of the current neuron use the new data.
- config_dst_num is sampled at each handshake, so a change mid-burst takes effect at the next comparison.
- config_spk_enable low only blocks pushes; queued spikes still drain.
- config_spk_clear has priority over everything except reset:
  - Next clk: FIFO is emptied, flit_out_vld=0, FSM goes to IDLE, overflow is cleared.
  - A pending flit is abandoned without a handshake.
- spk_out_busy = (cnt != 0) | flit_out_vld | (state != IDLE), registered.
- Simultaneous push and pop on a non-full FIFO leaves cnt unchanged. Pointers wrap modulo 16.

Decomposition:
- Shared package holds:
  - flit type codes (SPK_TYPE and the other node flit types);
  - FW, FTW, SW, DST_WIDTH defaults;
  - flit field offset constants;
  - FSM state encoding.
- One sub-module, sync_fifo: parameterised width and address width, registered count, full/empty flags, synchronous active-low reset. It is instantiated with width NNW.
- The destination table is a plain register array inside spk_out_tx.

Test Plan:
- Single fire, full fanout: dst_num=2, table={0x00011,0x00102}, fire id 0x005, rdy=1.
  - Required: two consecutive flits {010,0x00011,0x000005,0} then {010,0x00102,0x000005,0}.
  - First flit_out_vld appears 3 cycles after the fire; busy returns low afterwards.
- Backpressure: rdy held 0 for 5 cycles during flit 1.
  - Required: flit_out bit-stable and vld high throughout; flit 2 follows the cycle after rdy rises; no flit is lost or duplicated.
- Overflow: 18 fires in consecutive cycles with rdy=0.
  - Required: cnt saturates at 16 and overflow=1.
  - After rdy=1, exactly 16 IDs (the first 16) drain in order, each with dst_num flits.
- dst_num=0: 3 fires.
  - Required: no flit_out_vld ever; FIFO drains to 0 and busy falls.
- Clear mid-burst: 4 queued IDs, clear pulsed while vld=1 and rdy=0.
  - Required: next cycle vld=0, cnt=0, overflow=0, busy=0; subsequent fires are transmitted normally.
- Reset mid-operation and enable gating:
  - rst_n low while SEND: all outputs are 0 after the clock edge.
  - config_spk_enable=0 with fires present: no pushes occur, while previously queued IDs still transmit.

Source files
------------

// File: rtl/spk_out_tx_pkg.sv
// Shared constants for the node flit formats and the spike transmitter FSM.
package spk_out_tx_pkg;

  localparam int FW_DEF        = 59;
  localparam int FTW_DEF       = 3;
  localparam int SW_DEF        = 24;
  localparam int DST_WIDTH_DEF = 21;
  localparam int NNW_DEF       = 12;

  localparam logic [2:0] FLIT_TYPE_CFG = 3'b000;
  localparam logic [2:0] FLIT_TYPE_WGT = 3'b001;
  localparam logic [2:0] FLIT_TYPE_SPK = 3'b010;
  localparam logic [2:0] FLIT_TYPE_RD  = 3'b011;
  localparam logic [2:0] FLIT_TYPE_ACK = 3'b100;

  // Field LSB positions inside a default-width flit, type field at the top
  localparam int FLIT_TYPE_LSB = FW_DEF - FTW_DEF;
  localparam int FLIT_DST_LSB  = FLIT_TYPE_LSB - DST_WIDTH_DEF;
  localparam int FLIT_SPK_LSB  = FLIT_DST_LSB - SW_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spk_out_tx_if.sv
// Flit injection handshake between the spike transmitter and the router port.
interface spk_out_tx_if;
  import spk_out_tx_pkg::*;

  logic [FW_DEF-1:0] flit_out;
  logic              flit_out_vld;
  logic              flit_out_rdy;

  modport master (output flit_out, output flit_out_vld, input flit_out_rdy);
  modport slave  (input flit_out, input flit_out_vld, output flit_out_rdy);
endinterface

// File: rtl/spk_out_tx_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head word is visible on rd_data.
module sync_fifo #(
  parameter int W  = 12,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  cnt,
  output logic         full,
  output logic         empty
);
  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_r [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign full    = (cnt_r == DEPTH);
  assign empty   = (cnt_r == {(AW+1){1'b0}});
  assign cnt     = cnt_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify requests against the pre-operation full/empty state
  always_comb begin
    wr_ok_s = wr_en & ~full & ~clr;
    rd_ok_s = rd_en & ~empty & ~clr;
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the array size
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      cnt_r <= cnt_r + {{AW{1'b0}}, wr_ok_s} - {{AW{1'b0}}, rd_ok_s};
    end
  end
endmodule

// File: rtl/spk_out_tx.sv
// Spike transmitter: queues fired neuron IDs and emits one spike flit per
// configured destination onto the router injection port.
module spk_out_tx
  import spk_out_tx_pkg::*;
#(
  parameter int              FW        = FW_DEF,
  parameter int              FTW       = FTW_DEF,
  parameter int              NNW       = NNW_DEF,
  parameter int              SW        = SW_DEF,
  parameter int              DST_WIDTH = DST_WIDTH_DEF,
  parameter int              DST_DEPTH = 4,
  parameter int              FIFO_AW   = 4,
  parameter logic [FTW-1:0]  SPK_TYPE  = FLIT_TYPE_SPK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         soma_fire_vld,
  input  logic                         soma_spk_out_fire,
  input  logic [NNW-1:0]               soma_neuron_id,
  input  logic                         config_spk_enable,
  input  logic                         config_spk_clear,
  input  logic                         config_dst_we,
  input  logic [$clog2(DST_DEPTH)-1:0] config_dst_waddr,
  input  logic [DST_WIDTH-1:0]         config_dst_wdata,
  input  logic [$clog2(DST_DEPTH):0]   config_dst_num,
  spk_out_tx_if.master                 tx,
  output logic                         spk_out_busy,
  output logic                         spk_out_overflow,
  output logic [FIFO_AW:0]             spk_fifo_cnt
);
  localparam int DAW  = $clog2(DST_DEPTH);
  localparam int NUMW = DAW + 1;
  localparam logic [NUMW-1:0] NUM_ONE = {{(NUMW-1){1'b0}}, 1'b1};
  localparam logic [DAW-1:0]  IDX_ONE = {{(DAW-1){1'b0}}, 1'b1};

  tx_state_e             state_r, state_nxt_s;
  logic [DST_WIDTH-1:0]  dst_tab_r [0:DST_DEPTH-1];
  logic [FW-1:0]         flit_r;
  logic                  vld_r, busy_r, ovf_r;
  logic [NNW-1:0]        nid_r;
  logic [DAW-1:0]        dst_idx_r;
  logic [DAW-1:0]        dst_idx_nxt_s;
  logic [NNW-1:0]        head_s;
  logic [FIFO_AW:0]      fifo_cnt_s, cnt_nxt_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic                  push_req_s, push_ok_s, pop_s, pop_ok_s, more_s;
  logic                  load_first_s, load_next_s, done_s, vld_nxt_s, busy_nxt_s;

  function automatic logic [FW-1:0] mk_flit(input logic [DST_WIDTH-1:0] dst,
                                            input logic [NNW-1:0] nid);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: FTW]                     = SPK_TYPE;
    f[FW-FTW-1 -: DST_WIDTH]           = dst;
    f[FW-FTW-DST_WIDTH-1 -: SW]        = {{(SW-NNW){1'b0}}, nid};
    return f;
  endfunction

  sync_fifo #(.W(NNW), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (config_spk_clear),
    .wr_en   (push_req_s),
    .wr_data (soma_neuron_id),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .cnt     (fifo_cnt_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign tx.flit_out       = flit_r;
  assign tx.flit_out_vld   = vld_r;
  assign spk_out_busy      = busy_r;
  assign spk_out_overflow  = ovf_r;
  assign spk_fifo_cnt      = fifo_cnt_s;

  // Push qualification and burst position
  always_comb begin
    push_req_s    = soma_fire_vld & soma_spk_out_fire & config_spk_enable & ~config_spk_clear;
    push_ok_s     = push_req_s & ~fifo_full_s;
    dst_idx_nxt_s = dst_idx_r + IDX_ONE;
    more_s        = (({1'b0, dst_idx_r}) + NUM_ONE) < config_dst_num;
  end

  // Next-state and transmit strobes; clear overrides every state
  always_comb begin
    state_nxt_s  = state_r;
    pop_s        = 1'b0;
    load_first_s = 1'b0;
    load_next_s  = 1'b0;
    done_s       = 1'b0;
    if (config_spk_clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) state_nxt_s = ST_LOAD;
          else               state_nxt_s = ST_IDLE;
        end
        ST_LOAD: begin
          pop_s = 1'b1;
          if (config_dst_num == {NUMW{1'b0}}) begin
            // ID discarded; keep draining while more remain behind it
            if (fifo_cnt_s > {{FIFO_AW{1'b0}}, 1'b1}) state_nxt_s = ST_LOAD;
            else                                      state_nxt_s = ST_IDLE;
          end else begin
            load_first_s = 1'b1;
            state_nxt_s  = ST_SEND;
          end
        end
        ST_SEND: begin
          if (vld_r && tx.flit_out_rdy) begin
            if (more_s) begin
              load_next_s = 1'b1;
              state_nxt_s = ST_SEND;
            end else begin
              done_s = 1'b1;
              if (!fifo_empty_s) state_nxt_s = ST_LOAD;
              else               state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_SEND;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Look-ahead of occupancy, valid and busy so busy is exact when registered
  always_comb begin
    pop_ok_s  = pop_s & ~fifo_empty_s;
    vld_nxt_s = ~config_spk_clear & (load_first_s | load_next_s | (vld_r & ~done_s));
    if (config_spk_clear) begin
      cnt_nxt_s = {(FIFO_AW+1){1'b0}};
    end else begin
      cnt_nxt_s = fifo_cnt_s + {{FIFO_AW{1'b0}}, push_ok_s} - {{FIFO_AW{1'b0}}, pop_ok_s};
    end
    busy_nxt_s = (cnt_nxt_s != {(FIFO_AW+1){1'b0}}) | vld_nxt_s | (state_nxt_s != ST_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Destination table, writable at any time
  always_ff @(posedge clk) begin
    if (config_dst_we) dst_tab_r[config_dst_waddr] <= config_dst_wdata;
  end

  // Flit register, burst bookkeeping and status flags
  always_ff @(posedge clk) begin
    if (!rst_n || config_spk_clear) begin
      flit_r    <= {FW{1'b0}};
      vld_r     <= 1'b0;
      nid_r     <= {NNW{1'b0}};
      dst_idx_r <= {DAW{1'b0}};
      busy_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      vld_r  <= vld_nxt_s;
      busy_r <= busy_nxt_s;
      if (push_req_s && fifo_full_s) ovf_r <= 1'b1;
      if (pop_s) begin
        nid_r     <= head_s;
        dst_idx_r <= {DAW{1'b0}};
      end
      if (load_first_s) begin
        flit_r <= mk_flit(dst_tab_r[{DAW{1'b0}}], head_s);
      end else if (load_next_s) begin
        flit_r    <= mk_flit(dst_tab_r[dst_idx_nxt_s], nid_r);
        dst_idx_r <= dst_idx_nxt_s;
      end
    end
  end
endmodule

// File: tb/tb_spk_out_tx.sv
// Directed and randomized checks of spk_out_tx against a queue-based flit model.
module tb_spk_out_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soma_fire_vld = 1'b0;
  logic        soma_spk_out_fire = 1'b0;
  logic [11:0] soma_neuron_id = 12'h000;
  logic        config_spk_enable = 1'b1;
  logic        config_spk_clear = 1'b0;
  logic        config_dst_we = 1'b0;
  logic [1:0]  config_dst_waddr = 2'd0;
  logic [20:0] config_dst_wdata = 21'h0;
  logic [2:0]  config_dst_num = 3'd0;
  logic        spk_out_busy;
  logic        spk_out_overflow;
  logic [4:0]  spk_fifo_cnt;

  int total = 0;
  int bad = 0;
  int m_num = 0;
  logic [20:0] mtab [4];
  logic [58:0] exp_q [$];
  logic [58:0] got_q [$];

  always #5 clk = ~clk;

  spk_out_tx_if bus();
  initial bus.flit_out_rdy = 1'b0;

  spk_out_tx dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .soma_fire_vld     (soma_fire_vld),
    .soma_spk_out_fire (soma_spk_out_fire),
    .soma_neuron_id    (soma_neuron_id),
    .config_spk_enable (config_spk_enable),
    .config_spk_clear  (config_spk_clear),
    .config_dst_we     (config_dst_we),
    .config_dst_waddr  (config_dst_waddr),
    .config_dst_wdata  (config_dst_wdata),
    .config_dst_num    (config_dst_num),
    .tx                (bus),
    .spk_out_busy      (spk_out_busy),
    .spk_out_overflow  (spk_out_overflow),
    .spk_fifo_cnt      (spk_fifo_cnt)
  );

  // Record every flit the downstream side accepts
  always @(negedge clk) begin
    if (rst_n && !config_spk_clear && bus.flit_out_vld && bus.flit_out_rdy)
      got_q.push_back(bus.flit_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [58:0] mk(input logic [20:0] d, input logic [11:0] id);
    return {3'b010, d, 12'h000, id, 11'h000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fire(input logic [11:0] id);
    for (int d = 0; d < m_num; d++) exp_q.push_back(mk(mtab[d], id));
  endtask

  task automatic write_dst(input logic [1:0] a, input logic [20:0] d);
    config_dst_we = 1'b1; config_dst_waddr = a; config_dst_wdata = d;
    mtab[a] = d;
    step();
    config_dst_we = 1'b0;
  endtask

  task automatic set_num(input int n);
    config_dst_num = 3'(n);
    m_num = n;
  endtask

  task automatic fire(input logic [11:0] id);
    soma_fire_vld = 1'b1; soma_spk_out_fire = 1'b1; soma_neuron_id = id;
    if (config_spk_enable) model_fire(id);
    step();
    soma_fire_vld = 1'b0; soma_spk_out_fire = 1'b0;
  endtask

  task automatic wait_vld(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.flit_out_vld) break;
    end
    check("wait_vld", 64'(bus.flit_out_vld), 64'd1);
  endtask

  task automatic drain(input int maxc, input bit rnd);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!spk_out_busy && got_q.size() == exp_q.size()) break;
      step();
      if (rnd) bus.flit_out_rdy = 1'($urandom_range(0, 1));
    end
    check("drain_busy", 64'(spk_out_busy), 64'd0);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_flit"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_vld", 64'(bus.flit_out_vld), 64'd0);
    check("rst_flit", 64'(bus.flit_out), 64'd0);
    check("rst_busy", 64'(spk_out_busy), 64'd0);
    check("rst_ovf", 64'(spk_out_overflow), 64'd0);
    check("rst_cnt", 64'(spk_fifo_cnt), 64'd0);
    step();
    rst_n = 1'b1;

    // Single fire, two destinations, latency and back-to-back flits
    write_dst(2'd0, 21'h00011);
    write_dst(2'd1, 21'h00102);
    set_num(2);
    bus.flit_out_rdy = 1'b1;
    step();
    fire(12'h005);
    @(negedge clk); check("lat_t1_vld", 64'(bus.flit_out_vld), 64'd0);
    @(negedge clk); check("lat_t2_vld", 64'(bus.flit_out_vld), 64'd0);
    @(negedge clk); check("lat_t3_vld", 64'(bus.flit_out_vld), 64'd1);
    check("single_f0", 64'(bus.flit_out), 64'(mk(21'h00011, 12'h005)));
    @(negedge clk); check("single_vld1", 64'(bus.flit_out_vld), 64'd1);
    check("single_f1", 64'(bus.flit_out), 64'(mk(21'h00102, 12'h005)));
    @(negedge clk); check("single_end_vld", 64'(bus.flit_out_vld), 64'd0);
    check("single_end_busy", 64'(spk_out_busy), 64'd0);
    cmp_stream("single");

    // Backpressure on the first flit for five cycles
    step();
    bus.flit_out_rdy = 1'b0;
    fire(12'h0AB);
    wait_vld(10);
    check("bp_hold0", 64'(bus.flit_out), 64'(mk(mtab[0], 12'h0AB)));
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_vld", 64'(bus.flit_out_vld), 64'd1);
      check("bp_hold_flit", 64'(bus.flit_out), 64'(mk(mtab[0], 12'h0AB)));
    end
    step();
    bus.flit_out_rdy = 1'b1;
    @(negedge clk); check("bp_rel_f0", 64'(bus.flit_out), 64'(mk(mtab[0], 12'h0AB)));
    @(negedge clk); check("bp_rel_f1", 64'(bus.flit_out), 64'(mk(mtab[1], 12'h0AB)));
    @(negedge clk); check("bp_end_vld", 64'(bus.flit_out_vld), 64'd0);
    cmp_stream("bp");

    // Overflow: one ID stalled in transmission, then 18 fires into a 16-deep queue
    step();
    bus.flit_out_rdy = 1'b0;
    fire(12'h100);
    wait_vld(10);
    step();
    for (int i = 0; i < 18; i++) begin
      soma_fire_vld = 1'b1; soma_spk_out_fire = 1'b1; soma_neuron_id = 12'h200 + 12'(i);
      if (i < 16) model_fire(12'h200 + 12'(i));
      step();
    end
    soma_fire_vld = 1'b0; soma_spk_out_fire = 1'b0;
    @(negedge clk);
    check("ovf_cnt", 64'(spk_fifo_cnt), 64'd16);
    check("ovf_flag", 64'(spk_out_overflow), 64'd1);
    step();
    bus.flit_out_rdy = 1'b1;
    drain(300, 1'b0);
    check("ovf_sticky", 64'(spk_out_overflow), 64'd1);
    cmp_stream("ovf");

    // No destinations: IDs are consumed silently
    step();
    set_num(0);
    begin
      bit saw;
      saw = 1'b0;
      fire(12'h011); fire(12'h022); fire(12'h033);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        saw = saw | bus.flit_out_vld;
      end
      check("dst0_no_vld", 64'(saw), 64'd0);
    end
    check("dst0_cnt", 64'(spk_fifo_cnt), 64'd0);
    check("dst0_busy", 64'(spk_out_busy), 64'd0);
    cmp_stream("dst0");

    // Clear while a flit is stalled with IDs queued behind it
    step();
    set_num(2);
    bus.flit_out_rdy = 1'b0;
    fire(12'h301); fire(12'h302); fire(12'h303); fire(12'h304);
    wait_vld(10);
    step();
    config_spk_clear = 1'b1;
    step();
    config_spk_clear = 1'b0;
    @(negedge clk);
    check("clr_vld", 64'(bus.flit_out_vld), 64'd0);
    check("clr_cnt", 64'(spk_fifo_cnt), 64'd0);
    check("clr_ovf", 64'(spk_out_overflow), 64'd0);
    check("clr_busy", 64'(spk_out_busy), 64'd0);
    got_q.delete();
    exp_q.delete();
    step();
    bus.flit_out_rdy = 1'b1;
    fire(12'h401); fire(12'h402);
    drain(100, 1'b0);
    cmp_stream("post_clr");

    // Enable low blocks new pushes but queued IDs still go out
    step();
    set_num(1);
    bus.flit_out_rdy = 1'b0;
    fire(12'h501); fire(12'h502);
    wait_vld(10);
    step();
    config_spk_enable = 1'b0;
    fire(12'h601); fire(12'h602); fire(12'h603);
    @(negedge clk);
    check("en_cnt", 64'(spk_fifo_cnt), 64'd1);
    step();
    bus.flit_out_rdy = 1'b1;
    drain(100, 1'b0);
    cmp_stream("en_gate");
    config_spk_enable = 1'b1;

    // Reset while transmitting
    step();
    bus.flit_out_rdy = 1'b0;
    fire(12'h7AA); fire(12'h7AB);
    wait_vld(10);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rst2_vld", 64'(bus.flit_out_vld), 64'd0);
    check("rst2_flit", 64'(bus.flit_out), 64'd0);
    check("rst2_busy", 64'(spk_out_busy), 64'd0);
    check("rst2_cnt", 64'(spk_fifo_cnt), 64'd0);
    check("rst2_ovf", 64'(spk_out_overflow), 64'd0);
    step();
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();

    // Randomized rounds: random table, fanout, IDs, gaps and ready pattern
    for (int r = 0; r < 4; r++) begin
      int left;
      for (int a = 0; a < 4; a++) write_dst(2'(a), 21'($urandom));
      set_num($urandom_range(1, 4));
      left = $urandom_range(4, 12);
      for (int c = 0; c < 60; c++) begin
        bus.flit_out_rdy = 1'($urandom_range(0, 1));
        if (left > 0 && $urandom_range(0, 2) == 0) begin
          soma_fire_vld = 1'b1; soma_spk_out_fire = 1'b1;
          soma_neuron_id = 12'($urandom);
          model_fire(soma_neuron_id);
          left--;
        end else begin
          soma_fire_vld = 1'($urandom_range(0, 1)); soma_spk_out_fire = 1'b0;
          soma_neuron_id = 12'($urandom);
        end
        step();
      end
      soma_fire_vld = 1'b0; soma_spk_out_fire = 1'b0;
      drain(600, 1'b1);
      cmp_stream("rand");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
